// File: rtl/dm_access_controller_if.sv
// Request/response handshake bundle between a CPU-side requester and dm_access_controller.
// The master drives requests and consumes responses; the slave is the controller.
interface dm_access_controller_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0]    req_wdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_write;
    logic [DATA_WIDTH-1:0]    rsp_rdata;

    modport master (
        output req_valid, req_write, req_address, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_write, rsp_rdata
    );
endinterface

// File: rtl/dm_access_controller.sv
// Single-outstanding load/store initiator for a data memory with a registered read path.
// Drives address/data/enables with exact cycle timing and returns one response per request.
module dm_access_controller #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    dm_access_controller_if.slave    bus,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] DM_address,
    output logic                     Write_Enable,
    output logic [DATA_WIDTH-1:0]    DATA_WRITE,
    output logic                     Read_Enable,
    input  logic [DATA_WIDTH-1:0]    DATA_READ
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    rsp_valid_q;
    logic                    rsp_write_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;

    // Ready is a decode of the state register, masked while reset is held.
    assign bus.req_ready = (state == S_IDLE) && !reset;
    assign busy          = (state != S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            DM_address   <= '0;
            DATA_WRITE   <= '0;
            Write_Enable <= 1'b0;
            Read_Enable  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        DM_address  <= bus.req_address;
                        DATA_WRITE  <= bus.req_wdata;
                        rsp_rdata_q <= bus.req_wdata;
                        rsp_write_q <= bus.req_write;
                        if (bus.req_write) begin
                            Write_Enable <= 1'b1;
                            state        <= S_WRITE;
                        end else begin
                            Read_Enable <= 1'b1;
                            state       <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    Write_Enable <= 1'b0;
                    rsp_valid_q  <= 1'b1;
                    state        <= S_RESP;
                end
                S_READ: begin
                    Read_Enable <= 1'b0;
                    wait_cnt    <= CNT_W'(READ_LATENCY);
                    state       <= S_WAIT;
                end
                // Count down the memory's read pipeline; capture on the last stage.
                S_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt <= CNT_W'(1)) begin
                        wait_cnt    <= '0;
                        rsp_rdata_q <= DATA_READ;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_controller.sv
// Scoreboard bench for dm_access_controller: a READ_LATENCY=1 instance and a
// READ_LATENCY=3 instance, each attached to its own behavioural data memory.
module tb_dm_access_controller;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic clock = 1'b0;
    logic reset;
    logic mem_init;
    always #5 clock = ~clock;

    dm_access_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_a ();
    dm_access_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_b ();

    logic          busy_a, we_a, re_a, busy_b, we_b, re_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] dw_a, dr_a, dw_b, dr_b;

    dm_access_controller #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(1)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a), .busy(busy_a),
        .DM_address(addr_a), .Write_Enable(we_a), .DATA_WRITE(dw_a),
        .Read_Enable(re_a), .DATA_READ(dr_a)
    );

    dm_access_controller #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(3)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b), .busy(busy_b),
        .DM_address(addr_b), .Write_Enable(we_b), .DATA_WRITE(dw_b),
        .Read_Enable(re_b), .DATA_READ(dr_b)
    );

    // Memories: A has a one-register read path, B a three-stage one (stale value 0x3C).
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] rd_a;
    logic [DW-1:0] pipe_b [3];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= (i == 7) ? 8'hA5 : 8'h00;
            end
            rd_a <= 8'h00;
            for (int i = 0; i < 3; i++) pipe_b[i] <= 8'h3C;
        end else begin
            if (we_a) mem_a[addr_a] <= dw_a;
            if (re_a) rd_a <= mem_a[addr_a];
            if (we_b) mem_b[addr_b] <= dw_b;
            if (re_b) pipe_b[0] <= mem_b[addr_b];
            pipe_b[1] <= pipe_b[0];
            pipe_b[2] <= pipe_b[1];
        end
    end
    assign dr_a = rd_a;
    assign dr_b = pipe_b[2];

    int tests = 0;
    int fails = 0;
    int overlap = 0;
    logic [8:0] exp_a [$];
    logic [8:0] exp_b [$];
    logic [8:0] e_a, e_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response monitors: pop the scoreboard on every accepted response.
    always @(negedge clock) begin
        if (we_a && re_a) overlap++;
        if (we_b && re_b) overlap++;
        if (!reset && bus_a.rsp_valid && bus_a.rsp_ready) begin
            check("a_rsp_expected", 32'(exp_a.size() != 0), 1);
            if (exp_a.size() != 0) begin
                e_a = exp_a.pop_front();
                check("a_rsp_write", 32'(bus_a.rsp_write), 32'(e_a[8]));
                check("a_rsp_rdata", 32'(bus_a.rsp_rdata), 32'(e_a[7:0]));
            end
        end
        if (!reset && bus_b.rsp_valid && bus_b.rsp_ready) begin
            check("b_rsp_expected", 32'(exp_b.size() != 0), 1);
            if (exp_b.size() != 0) begin
                e_b = exp_b.pop_front();
                check("b_rsp_write", 32'(bus_b.rsp_write), 32'(e_b[8]));
                check("b_rsp_rdata", 32'(bus_b.rsp_rdata), 32'(e_b[7:0]));
            end
        end
    end

    // One transaction on instance A with rsp_ready=1; entered and left at a negedge.
    task automatic txn_a(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_d);
        int lat, we_n, re_n, re_at;
        check("a_req_ready_idle", 32'(bus_a.req_ready), 1);
        bus_a.req_valid   = 1'b1;
        bus_a.req_write   = w;
        bus_a.req_address = a;
        bus_a.req_wdata   = d;
        exp_a.push_back({w, exp_d});
        @(negedge clock);
        bus_a.req_valid   = 1'b0;
        bus_a.req_write   = ~w;
        bus_a.req_address = ~a;
        bus_a.req_wdata   = ~d;
        lat = 1; we_n = 0; re_n = 0; re_at = 0;
        while (!bus_a.rsp_valid && lat < 20) begin
            check("a_busy", 32'(busy_a), 1);
            check("a_req_ready_busy", 32'(bus_a.req_ready), 0);
            if (we_a) begin
                we_n++;
                check("a_we_addr", 32'(addr_a), 32'(a));
                check("a_we_data", 32'(dw_a), 32'(d));
            end
            if (re_a) begin
                re_n++;
                re_at = lat;
                check("a_re_addr", 32'(addr_a), 32'(a));
            end
            @(negedge clock);
            lat++;
        end
        check("a_rsp_latency", 32'(lat), w ? 32'd2 : 32'd3);
        check("a_we_cycles", 32'(we_n), w ? 32'd1 : 32'd0);
        check("a_re_cycles", 32'(re_n), w ? 32'd0 : 32'd1);
        if (!w) check("a_re_cycle_index", 32'(re_at), 1);
        @(negedge clock);
        check("a_busy_after", 32'(busy_a), 0);
        check("a_req_ready_after", 32'(bus_a.req_ready), 1);
        check("a_addr_held", 32'(addr_a), 32'(a));
        check("a_wdata_held", 32'(dw_a), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mem_init = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_address = '0;
        bus_a.req_wdata = '0;   bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_address = '0;
        bus_b.req_wdata = '0;   bus_b.rsp_ready = 1'b1;
        @(negedge clock);
        mem_init = 1'b0;

        // Reset state, with req_ready masked while reset is high
        check("rst_outputs_a",
              32'({bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_write, bus_a.rsp_rdata,
                   busy_a, addr_a, dw_a, we_a, re_a}), 0);
        check("rst_outputs_b",
              32'({bus_b.req_ready, bus_b.rsp_valid, busy_b, addr_b, dw_b, we_b, re_b}), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_release_ready", 32'(bus_a.req_ready), 1);

        // Load from zero-filled memory; wdata must not leak into the response
        txn_a(1'b0, 4'h9, 8'h5A, 8'h00);
        // Store then load the same address
        txn_a(1'b1, 4'h9, 8'hC5, 8'hC5);
        txn_a(1'b0, 4'h9, 8'h00, 8'hC5);
        // Top address must not alias onto low addresses
        txn_a(1'b1, 4'hF, 8'h09, 8'h09);
        txn_a(1'b1, 4'h1, 8'h0F, 8'h0F);
        txn_a(1'b0, 4'hF, 8'h00, 8'h09);
        txn_a(1'b0, 4'h1, 8'h00, 8'h0F);

        // Back-pressured load response with a stray request pulse
        bus_a.rsp_ready   = 1'b0;
        bus_a.req_valid   = 1'b1;
        bus_a.req_write   = 1'b0;
        bus_a.req_address = 4'h1;
        bus_a.req_wdata   = 8'h00;
        exp_a.push_back({1'b0, 8'h0F});
        @(negedge clock);
        bus_a.req_valid = 1'b0;
        for (int i = 0; i < 10 && !bus_a.rsp_valid; i++) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus_a.rsp_valid), 1);
            check("bp_rsp_rdata", 32'(bus_a.rsp_rdata), 32'h0F);
            check("bp_req_ready", 32'(bus_a.req_ready), 0);
            check("bp_no_enable", 32'({we_a, re_a}), 0);
            if (i == 1) begin
                bus_a.req_valid   = 1'b1;
                bus_a.req_write   = 1'b1;
                bus_a.req_address = 4'h3;
                bus_a.req_wdata   = 8'hEE;
            end else begin
                bus_a.req_valid = 1'b0;
            end
            @(negedge clock);
        end
        bus_a.req_valid = 1'b0;
        @(posedge clock);
        #1 bus_a.rsp_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp_idle_after", 32'(busy_a), 0);
        check("bp_queue_drained", 32'(exp_a.size()), 0);
        txn_a(1'b0, 4'h3, 8'h00, 8'h00);

        // Reset during the WAIT cycle of a load aborts it without a response
        bus_a.req_valid   = 1'b1;
        bus_a.req_write   = 1'b0;
        bus_a.req_address = 4'hF;
        bus_a.req_wdata   = 8'h00;
        @(negedge clock);
        bus_a.req_valid = 1'b0;
        check("abort_read_cycle", 32'(re_a), 1);
        @(negedge clock);
        check("abort_wait_busy", 32'(busy_a), 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_outputs_zero",
              32'({bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_write, bus_a.rsp_rdata,
                   busy_a, addr_a, dw_a, we_a, re_a}), 0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_no_rsp", 32'(bus_a.rsp_valid), 0);
        check("abort_ready", 32'(bus_a.req_ready), 1);
        txn_a(1'b0, 4'hF, 8'h00, 8'h09);

        // READ_LATENCY=3: capture at end of cycle 4, response in cycle 5
        bus_b.req_valid   = 1'b1;
        bus_b.req_write   = 1'b0;
        bus_b.req_address = 4'h7;
        bus_b.req_wdata   = 8'h00;
        exp_b.push_back({1'b0, 8'hA5});
        @(negedge clock);
        bus_b.req_valid = 1'b0;
        check("b_re_cycle1", 32'(re_b), 1);
        check("b_re_addr", 32'(addr_b), 32'h7);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clock);
            check("b_no_early_rsp", 32'(bus_b.rsp_valid), 0);
            check("b_busy_wait", 32'(busy_b), 1);
            check("b_no_enable_wait", 32'({we_b, re_b}), 0);
        end
        @(negedge clock);
        check("b_rsp_cycle5", 32'(bus_b.rsp_valid), 1);
        @(negedge clock);
        check("b_idle_after", 32'(busy_b), 0);

        check("a_pending_rsp", 32'(exp_a.size()), 0);
        check("b_pending_rsp", 32'(exp_b.size()), 0);
        check("enable_overlap", 32'(overlap), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
